fifo_cmd_unpacker: RTL and testbench
====================================

# fifo_cmd_unpacker

Drains the 64-bit, 256-deep command `scfifo` (normal mode, `lpm_showahead` OFF, q valid the cycle after `rdreq`). Decodes the word stream into whole graphics commands: single-word commands plus a four-word triangle command. Presents each command as one parallel bundle to the downstream rasterizer over a valid/ready handshake. Sits directly downstream of the FIFO's read port.

## Interface
Parameters:
- `ERROR_COUNT_WIDTH`, default 16: width of the saturating bad-opcode counter.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_q`  in  64  FIFO `q`; valid the cycle after `fifo_rdreq` was high.
- `fifo_rdreq`  out  1  FIFO `rdreq`; combinational from state and `fifo_empty`.
- `cmd_valid`  out  1  command bundle valid.
- `cmd_ready`  in  1  downstream accepts the bundle.
- `cmd_opcode`  out  8  header [7:0].
- `cmd_arg`  out  32  header [63:32].
- `cmd_v0`, `cmd_v1`, `cmd_v2`  out  64 each  triangle vertex words, in FIFO order.
- `busy`  out  1  high in every state except S_IDLE.
- `error_count`  out  ERROR_COUNT_WIDTH  saturating count of unknown opcodes.

## Operation
- Header word: opcode [7:0], argument [63:32], bits [31:8] ignored.
- Vertex word: x [15:0], y [31:16], rgb [55:32], [63:56] reserved. Passed through unmodified.
- Opcodes:
  - 0x00 NOP: consumed, dropped.
  - 0x01 CLEAR: arg = 24-bit colour in [23:0].
  - 0x02 TRIANGLE: header + 3 vertex words.
  - 0x03 SWAP: single word.
  - Any other opcode: dropped; `error_count` increments, saturating at all-ones.
- States:
  - S_IDLE: `fifo_rdreq` = !`fifo_empty`; if a read is issued, go to S_HEADER.
  - S_HEADER: latch `fifo_q` into opcode and arg.
    - 0x02: clear the vertex index, go to S_VREQ.
    - 0x01, 0x03: go to S_EMIT.
    - 0x00 or unknown: go to S_IDLE.
  - S_VREQ: `fifo_rdreq` = !`fifo_empty`; if a read is issued, go to S_VDATA; otherwise stay.
  - S_VDATA: latch `fifo_q` into v[idx].
    - idx == 2: go to S_EMIT.
    - Otherwise: idx++, go to S_VREQ.
  - S_EMIT: `cmd_valid` = 1; on `cmd_ready` go to S_IDLE.
- `fifo_rdreq` is never high while `fifo_empty` is high (no underflow) and never high outside S_IDLE/S_VREQ.
- At most one read is outstanding.
- Bundle registers hold their values from capture until the next overwrite. The `cmd_v*` outputs of a non-triangle command keep stale contents, and downstream ignores them.
- Reset values:
  - state S_IDLE.
  - `fifo_rdreq` 0 immediately (combinational).
  - `cmd_valid` 0, `busy` 0.
  - `cmd_opcode`/`cmd_arg`/`cmd_v*` 0.
  - `error_count` 0.
  - idx 0.
- Reset mid-command abandons the partial command; words already popped are lost. The system pulses the FIFO `sclr` together with `reset`.

## Timing
- Each FIFO word costs 2 cycles (request, capture); no back-to-back reads.
- CLEAR/SWAP with FIFO non-empty: rdreq at cycle 0, capture at 1, `cmd_valid` at 2.
- TRIANGLE with FIFO never empty: header rdreq at cycle 0, `cmd_valid` at cycle 8.
- From S_EMIT with `cmd_ready`=1, the next header rdreq can be issued in the cycle after the handshake. Back-to-back CLEARs therefore take 3 cycles each.
- `cmd_valid` and the bundle are registered, and stay stable while `cmd_valid` && !`cmd_ready`.
- No FIFO reads occur while stalled in S_EMIT.
- `fifo_empty` rising while in S_VREQ: wait indefinitely with `busy` high and no rdreq.
- `error_count` updates the cycle after S_HEADER.

## Test plan
- CLEAR, `cmd_ready` low for 5 cycles:
  - Stimulus: push 64'h00AB_CDEF_0000_0001; hold `cmd_ready` low for 5 cycles, then raise it.
  - Response: rdreq at cycle 0; `cmd_valid` at cycle 2 with opcode 0x01, arg 0x00ABCDEF; bundle stable and `fifo_rdreq` 0 for all 5 cycles; `busy` falls after the handshake.
- TRIANGLE, `cmd_ready`=1:
  - Stimulus: push 64'h...0002, then vertices 64'h0012_3456_0020_0010, 64'h0065_4321_0040_0030, 64'h00FF_FFFF_0060_0050.
  - Response: `cmd_valid` exactly 8 cycles after the first rdreq; v0/v1/v2 match those words in order; exactly 4 rdreq pulses.
- Empty stalls mid-triangle:
  - Stimulus: same triangle, but hold `fifo_empty` high for 10 cycles after the header and again after v0.
  - Response: `fifo_rdreq` 0 throughout both stalls; bundle identical to the previous test; `cmd_valid` at cycle 28.
- Dropped and unknown opcodes:
  - Stimulus: push NOP, opcode 0x7F, then SWAP 0x03.
  - Response: no `cmd_valid` for the first two words; `error_count` = 1; SWAP emitted with opcode 0x03.
- Reset mid-triangle:
  - Stimulus: assert `reset` while in S_VDATA after v1, pulse the FIFO `sclr` together with it, then push a CLEAR.
  - Response: all outputs return to their reset values at once; the CLEAR is decoded correctly, with no leftover vertex state affecting opcode or arg.
- `error_count` saturation, `ERROR_COUNT_WIDTH`=2:
  - Stimulus: push 5 unknown opcodes.
  - Response: count steps 1,2,3,3,3 and never wraps.

Source files
------------

// File: rtl/fifo_cmd_unpacker.sv
// Drains a show-ahead-off command FIFO and reassembles single-word and four-word
// triangle commands into one registered bundle with a valid/ready handshake.
module fifo_cmd_unpacker #(
    parameter int ERROR_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fifo_empty,
    input  logic [63:0]                  fifo_q,
    output logic                         fifo_rdreq,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [7:0]                   cmd_opcode,
    output logic [31:0]                  cmd_arg,
    output logic [63:0]                  cmd_v0,
    output logic [63:0]                  cmd_v1,
    output logic [63:0]                  cmd_v2,
    output logic                         busy,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_VREQ,
        S_VDATA,
        S_EMIT
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_TRI   = 8'h02;
    localparam logic [7:0] OP_SWAP  = 8'h03;

    state_t                       state_q;
    logic [1:0]                   idx_q;
    logic [7:0]                   opcode_q;
    logic [31:0]                  arg_q;
    logic [2:0][63:0]             vtx_q;
    logic                         valid_q;
    logic [ERROR_COUNT_WIDTH-1:0] err_q;

    // Only the two request states may pop; reset gates the strobe before the state settles.
    assign fifo_rdreq = !reset && !fifo_empty && (state_q == S_IDLE || state_q == S_VREQ);

    assign cmd_valid   = valid_q;
    assign cmd_opcode  = opcode_q;
    assign cmd_arg     = arg_q;
    assign cmd_v0      = vtx_q[0];
    assign cmd_v1      = vtx_q[1];
    assign cmd_v2      = vtx_q[2];
    assign busy        = (state_q != S_IDLE);
    assign error_count = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            opcode_q <= 8'h00;
            arg_q    <= 32'h0;
            vtx_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) state_q <= S_HEADER;
                end
                S_HEADER: begin
                    opcode_q <= fifo_q[7:0];
                    arg_q    <= fifo_q[63:32];
                    case (fifo_q[7:0])
                        OP_TRI: begin
                            idx_q   <= 2'd0;
                            state_q <= S_VREQ;
                        end
                        OP_CLEAR, OP_SWAP: begin
                            valid_q <= 1'b1;
                            state_q <= S_EMIT;
                        end
                        OP_NOP: state_q <= S_IDLE;
                        default: begin
                            if (err_q != '1) err_q <= err_q + 1'b1;
                            state_q <= S_IDLE;
                        end
                    endcase
                end
                S_VREQ: begin
                    if (!fifo_empty) state_q <= S_VDATA;
                end
                S_VDATA: begin
                    case (idx_q)
                        2'd0:    vtx_q[0] <= fifo_q;
                        2'd1:    vtx_q[1] <= fifo_q;
                        default: vtx_q[2] <= fifo_q;
                    endcase
                    if (idx_q == 2'd2) begin
                        valid_q <= 1'b1;
                        state_q <= S_EMIT;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= S_VREQ;
                    end
                end
                S_EMIT: begin
                    if (cmd_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_cmd_unpacker.sv
// Bench for fifo_cmd_unpacker: queue-backed FIFO model, stream-parsing command
// model and scoreboard, directed timing cases followed by random traffic.
module tb_fifo_cmd_unpacker;

    localparam int ECW  = 2;
    localparam int EMAX = (1 << ECW) - 1;

    logic            clock, reset, fifo_empty, fifo_rdreq, cmd_valid, cmd_ready, busy;
    logic [63:0]     fifo_q, cmd_v0, cmd_v1, cmd_v2;
    logic [7:0]      cmd_opcode;
    logic [31:0]     cmd_arg;
    logic [ECW-1:0]  error_count;

    fifo_cmd_unpacker #(.ERROR_COUNT_WIDTH(ECW)) dut (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
        .fifo_rdreq(fifo_rdreq), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg), .cmd_v0(cmd_v0), .cmd_v1(cmd_v1),
        .cmd_v2(cmd_v2), .busy(busy), .error_count(error_count)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] arg;
        logic [63:0] v0, v1, v2;
        bit          is_tri;
    } cmd_t;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    logic [63:0] fq[$];
    logic [63:0] pend;
    bit pend_v = 0, hold_empty = 0;
    cmd_t exp_q[$];
    cmd_t m_cur;
    int m_need = 0, m_err = 0;
    int rd_cyc[$];
    int v_rise = 0, hs_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // FIFO model: pop on the edge rdreq is seen, q valid from the following cycle.
    always @(posedge clock or negedge clock) begin
        if (clock) begin
            cyc++;
            if (reset) begin
                fq.delete();
                pend_v = 0;
            end else if (fifo_rdreq) begin
                pend   = fq.pop_front();
                pend_v = 1;
            end
        end else begin
            if (pend_v) begin
                fifo_q = pend;
                pend_v = 0;
            end
            fifo_empty = hold_empty || (fq.size() == 0);
        end
    end

    // Monitor and scoreboard
    bit st_flag = 0, v_prev = 0;
    logic [39:0] s_hdr;
    logic [63:0] s_v0, s_v1, s_v2;
    always @(negedge clock) begin
        #1;
        if (reset) begin
            st_flag = 0;
            v_prev  = 0;
        end else begin
            if (fifo_rdreq) begin
                rd_cyc.push_back(cyc);
                chk("rd_underflow", fifo_empty, 0);
                chk("rd_in_emit", cmd_valid, 0);
            end
            if (cmd_valid && !v_prev) v_rise = cyc;
            if (cmd_valid) chk("busy_emit", busy, 1);
            if (st_flag) begin
                chk("stable_hdr", {cmd_opcode, cmd_arg}, s_hdr);
                chk("stable_v0", cmd_v0, s_v0);
                chk("stable_v1", cmd_v1, s_v1);
                chk("stable_v2", cmd_v2, s_v2);
                chk("stable_vld", cmd_valid, 1);
            end
            st_flag = cmd_valid && !cmd_ready;
            s_hdr = {cmd_opcode, cmd_arg};
            s_v0 = cmd_v0; s_v1 = cmd_v1; s_v2 = cmd_v2;
            if (cmd_valid && cmd_ready) begin
                cmd_t e;
                hs_cnt++;
                chk("sb_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_op", cmd_opcode, e.op);
                    chk("sb_arg", cmd_arg, e.arg);
                    if (e.is_tri) begin
                        chk("sb_v0", cmd_v0, e.v0);
                        chk("sb_v1", cmd_v1, e.v1);
                        chk("sb_v2", cmd_v2, e.v2);
                    end
                end
            end
            v_prev = cmd_valid;
        end
    end

    // Reference: parse the pushed word stream into the commands it must yield.
    task automatic model_word(input logic [63:0] w);
        if (m_need > 0) begin
            case (m_need)
                3: m_cur.v0 = w;
                2: m_cur.v1 = w;
                default: begin
                    m_cur.v2 = w;
                    exp_q.push_back(m_cur);
                end
            endcase
            m_need--;
        end else begin
            m_cur.op = w[7:0];
            m_cur.arg = w[63:32];
            m_cur.is_tri = (w[7:0] == 8'h02);
            if (w[7:0] == 8'h02) m_need = 3;
            else if (w[7:0] == 8'h01 || w[7:0] == 8'h03) exp_q.push_back(m_cur);
            else if (w[7:0] != 8'h00 && m_err < EMAX) m_err++;
        end
    endtask

    task automatic push(input logic [63:0] w);
        fq.push_back(w);
        model_word(w);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_valid(input int lim);
        for (int i = 0; i < lim && !cmd_valid; i++) tick();
        chk("valid_timeout", cmd_valid, 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && (busy || fq.size() != 0 || pend_v); i++) tick();
        chk("idle_timeout", busy, 0);
    endtask

    function automatic logic [63:0] rnd_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: w[7:0] = 8'h00;
            1: w[7:0] = 8'h01;
            2, 3: w[7:0] = 8'h02;
            4: w[7:0] = 8'h03;
            default: w[7:0] = 8'($urandom_range(4, 255));
        endcase
        return w;
    endfunction

    localparam logic [63:0] TH  = 64'h0000_0007_0000_0002;
    localparam logic [63:0] TV0 = 64'h0012_3456_0020_0010;
    localparam logic [63:0] TV1 = 64'h0065_4321_0040_0030;
    localparam logic [63:0] TV2 = 64'h00FF_FFFF_0060_0050;

    initial begin
        int r, h0;
        logic [ECW-1:0] sat_exp[5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        reset = 1; cmd_ready = 0; fifo_q = '0; fifo_empty = 1;
        repeat (3) tick();
        chk("rst0_vld", cmd_valid, 0);
        chk("rst0_busy", busy, 0);
        chk("rst0_rd", fifo_rdreq, 0);
        chk("rst0_err", error_count, 0);
        chk("rst0_bundle", {cmd_opcode, cmd_arg, cmd_v0}, 0);
        reset = 0;
        tick();

        // CLEAR with downstream stalled for 5 cycles, second CLEAR queued meanwhile
        rd_cyc.delete();
        push(64'h00AB_CDEF_0000_0001);
        wait_valid(20);
        chk("clr_lat", cyc - rd_cyc[0], 2);
        chk("clr_op", cmd_opcode, 8'h01);
        chk("clr_arg", cmd_arg, 32'h00AB_CDEF);
        push(64'h0011_2233_0000_0001);
        repeat (5) tick();
        chk("clr_stall_rd", rd_cyc.size(), 1);
        cmd_ready = 1;
        tick();
        chk("clr_busy_fall", busy, 0);
        chk("clr_next_rd", fifo_rdreq, 1);
        r = cyc;
        wait_valid(20);
        chk("clr2_lat", cyc - r, 2);
        wait_idle(50);

        // back-to-back CLEARs at 3 cycles each
        rd_cyc.delete();
        repeat (3) push({$urandom, 32'h0000_0001});
        wait_idle(50);
        chk("b2b_n", rd_cyc.size(), 3);
        chk("b2b_gap0", rd_cyc[1] - rd_cyc[0], 3);
        chk("b2b_gap1", rd_cyc[2] - rd_cyc[1], 3);

        // TRIANGLE with FIFO never empty
        rd_cyc.delete();
        push(TH); push(TV0); push(TV1); push(TV2);
        wait_idle(50);
        chk("tri_lat", v_rise - rd_cyc[0], 8);
        chk("tri_nrd", rd_cyc.size(), 4);
        chk("tri_v0", cmd_v0, TV0);
        chk("tri_v1", cmd_v1, TV1);
        chk("tri_v2", cmd_v2, TV2);

        // TRIANGLE with two 10-cycle empty stalls
        rd_cyc.delete();
        push(TH); push(TV0); push(TV1); push(TV2);
        tick(); hold_empty = 1;
        repeat (4) tick();
        chk("stall_busy", busy, 1);
        chk("stall_rd", fifo_rdreq, 0);
        repeat (7) tick(); hold_empty = 0;
        tick(); hold_empty = 1;
        repeat (11) tick(); hold_empty = 0;
        wait_idle(80);
        chk("stall_lat", v_rise - rd_cyc[0], 28);
        chk("stall_nrd", rd_cyc.size(), 4);
        chk("stall_gap", rd_cyc[1] - rd_cyc[0], 12);
        chk("stall_v0", cmd_v0, TV0);
        chk("stall_v1", cmd_v1, TV1);
        chk("stall_v2", cmd_v2, TV2);

        // NOP and unknown dropped, SWAP emitted
        h0 = hs_cnt;
        push(64'h0000_0001_0000_0000);
        push(64'h0000_0002_0000_007F);
        push(64'h0000_0003_0000_0003);
        wait_idle(50);
        chk("drop_err", error_count, 1);
        chk("drop_hs", hs_cnt - h0, 1);
        chk("swap_op", cmd_opcode, 8'h03);

        // reset while capturing v1
        push(TH); push(TV0); push(TV1); push(TV2);
        repeat (5) tick();
        chk("rst_pre_busy", busy, 1);
        reset = 1;
        #1;
        chk("rst_rd", fifo_rdreq, 0);
        chk("rst_vld", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hdr", {cmd_opcode, cmd_arg}, 0);
        chk("rst_v0", cmd_v0, 0);
        chk("rst_v1", cmd_v1, 0);
        chk("rst_v2", cmd_v2, 0);
        chk("rst_err", error_count, 0);
        exp_q.delete(); m_need = 0; m_err = 0;
        tick(); tick();
        reset = 0;
        tick();
        h0 = hs_cnt;
        push(64'h0012_3456_0000_0001);
        wait_idle(50);
        chk("rst_clr_hs", hs_cnt - h0, 1);
        chk("rst_clr_arg", cmd_arg, 32'h0012_3456);

        // saturating error count
        for (int i = 0; i < 5; i++) begin
            push(64'h0000_0000_0000_00A5);
            wait_idle(50);
            chk($sformatf("sat%0d", i), error_count, sat_exp[i]);
        end

        // random traffic with random backpressure and empty bursts
        for (int i = 0; i < 1500; i++) begin
            cmd_ready  = ($urandom_range(0, 3) != 0);
            hold_empty = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) push(rnd_word());
            tick();
        end
        hold_empty = 0;
        cmd_ready  = 1;
        while (m_need > 0) push(rnd_word());
        wait_idle(20000);
        chk("rnd_drain", exp_q.size(), 0);
        chk("rnd_err", error_count, m_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
